// File: rtl/bcd_timekeeper_if.sv
// Control and time-display bundle for bcd_timekeeper: tick, adjust and preset
// requests in, registered BCD digits and status pulses out.
interface bcd_timekeeper_if;
  logic        clock_en;
  logic [5:0]  digit;
  logic        up;
  logic        down;
  logic        load;
  logic [23:0] load_time;
  logic        load_pm;
  logic [3:0]  sec0;
  logic [3:0]  sec1;
  logic [3:0]  min0;
  logic [3:0]  min1;
  logic [3:0]  hrs0;
  logic [3:0]  hrs1;
  logic        pm;
  logic        day_tick;
  logic        load_err;

  modport master (
    output clock_en, digit, up, down, load, load_time, load_pm,
    input  sec0, sec1, min0, min1, hrs0, hrs1, pm, day_tick, load_err
  );

  modport slave (
    input  clock_en, digit, up, down, load, load_time, load_pm,
    output sec0, sec1, min0, min1, hrs0, hrs1, pm, day_tick, load_err
  );
endinterface

// File: rtl/bcd_timekeeper.sv
// BCD time-of-day counter with 12/24-hour modes, per-digit adjust and preset load.
// Each cycle at most one of load, adjust or 1 Hz tick acts, in that priority.
module bcd_timekeeper #(
  parameter bit H24     = 1'b1,
  parameter bit LOAD_EN = 1'b1
) (
  input  logic            clk_6mhz,
  input  logic            rst,
  bcd_timekeeper_if.slave tk
);

  logic [3:0] s0_q, s1_q, m0_q, m1_q, h0_q, h1_q;
  logic       pm_q, day_q, err_q;
  logic [3:0] s0_d, s1_d, m0_d, m1_d, h0_d, h1_d;
  logic       pm_d, day_d, err_d;
  logic       load_act, load_ok, adj_vld;
  logic       c_s0, c_s1, c_m0, c_m1;
  logic [4:0] hr;

  function automatic logic [3:0] wrap_step(input logic [3:0] v, input logic [3:0] vmax,
                                           input logic inc);
    if (inc) return (v >= vmax) ? 4'd0 : v + 4'd1;
    return (v == 4'd0 || v > vmax) ? vmax : v - 4'd1;
  endfunction

  function automatic logic [4:0] hr_bin(input logic [3:0] h1, input logic [3:0] h0);
    return 5'(h1) * 5'd10 + 5'(h0);
  endfunction

  function automatic logic [7:0] hr_bcd(input logic [4:0] h);
    return (h >= 5'd10) ? {4'd1, 4'(h - 5'd10)} : {4'd0, h[3:0]};
  endfunction

  function automatic logic [4:0] hr12_step(input logic [4:0] h, input logic inc);
    if (inc) return (h == 5'd12) ? 5'd1 : h + 5'd1;
    return (h == 5'd1) ? 5'd12 : h - 5'd1;
  endfunction

  function automatic logic load_valid(input logic [23:0] t);
    logic bcd_ok, hr_ok;
    bcd_ok = (t[3:0] <= 4'd9) && (t[7:4] <= 4'd5) && (t[11:8] <= 4'd9) &&
             (t[15:12] <= 4'd5) && (t[19:16] <= 4'd9) && (t[23:20] <= 4'd9);
    if (H24)
      hr_ok = (t[23:20] < 4'd2) || (t[23:20] == 4'd2 && t[19:16] <= 4'd3);
    else
      hr_ok = (t[23:20] == 4'd0 && t[19:16] != 4'd0) ||
              (t[23:20] == 4'd1 && t[19:16] <= 4'd2);
    return bcd_ok && hr_ok;
  endfunction

  assign load_act = LOAD_EN && tk.load;
  assign load_ok  = load_valid(tk.load_time);
  assign adj_vld  = (tk.up ^ tk.down) && $onehot(tk.digit);
  assign hr       = hr_bin(h1_q, h0_q);

  // Carry chain resolved combinationally so a tick lands in one edge
  assign c_s0 = (s0_q == 4'd9);
  assign c_s1 = c_s0 && (s1_q == 4'd5);
  assign c_m0 = c_s1 && (m0_q == 4'd9);
  assign c_m1 = c_m0 && (m1_q == 4'd5);

  always_comb begin
    s0_d  = s0_q;
    s1_d  = s1_q;
    m0_d  = m0_q;
    m1_d  = m1_q;
    h0_d  = h0_q;
    h1_d  = h1_q;
    pm_d  = pm_q;
    day_d = 1'b0;
    err_d = 1'b0;
    if (load_act) begin
      if (load_ok) begin
        {h1_d, h0_d, m1_d, m0_d, s1_d, s0_d} = tk.load_time;
        if (!H24) pm_d = tk.load_pm;
      end else begin
        err_d = 1'b1;
      end
    end else if (adj_vld) begin
      if (tk.digit[5])      s0_d = wrap_step(s0_q, 4'd9, tk.up);
      else if (tk.digit[4]) s1_d = wrap_step(s1_q, 4'd5, tk.up);
      else if (tk.digit[3]) m0_d = wrap_step(m0_q, 4'd9, tk.up);
      else if (tk.digit[2]) m1_d = wrap_step(m1_q, 4'd5, tk.up);
      else if (tk.digit[1]) begin
        if (H24) h0_d = wrap_step(h0_q, (h1_q == 4'd2) ? 4'd3 : 4'd9, tk.up);
        else     {h1_d, h0_d} = hr_bcd(hr12_step(hr, tk.up));
      end else begin
        if (H24) begin
          h1_d = wrap_step(h1_q, 4'd2, tk.up);
          // 2x hours only go to 23, so a tens step onto 2 clamps the units
          if (h1_d == 4'd2 && h0_q > 4'd3) h0_d = 4'd3;
        end else begin
          pm_d = ~pm_q;
        end
      end
    end else if (tk.clock_en) begin
      s0_d = c_s0 ? 4'd0 : s0_q + 4'd1;
      if (c_s0) s1_d = c_s1 ? 4'd0 : s1_q + 4'd1;
      if (c_s1) m0_d = c_m0 ? 4'd0 : m0_q + 4'd1;
      if (c_m0) m1_d = c_m1 ? 4'd0 : m1_q + 4'd1;
      if (c_m1) begin
        if (H24) begin
          if (h1_q == 4'd2 && h0_q == 4'd3) begin
            h1_d  = 4'd0;
            h0_d  = 4'd0;
            day_d = 1'b1;
          end else if (h0_q == 4'd9) begin
            h0_d = 4'd0;
            h1_d = h1_q + 4'd1;
          end else begin
            h0_d = h0_q + 4'd1;
          end
        end else if (hr == 5'd12) begin
          {h1_d, h0_d} = 8'h01;
        end else begin
          {h1_d, h0_d} = hr_bcd(hr + 5'd1);
          // 11 -> 12 flips the meridian; pm -> am is midnight
          if (hr == 5'd11) begin
            pm_d  = ~pm_q;
            day_d = pm_q;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_6mhz or posedge rst) begin
    if (rst) begin
      s0_q  <= 4'd0;
      s1_q  <= 4'd0;
      m0_q  <= 4'd0;
      m1_q  <= 4'd0;
      h0_q  <= H24 ? 4'd0 : 4'd2;
      h1_q  <= H24 ? 4'd0 : 4'd1;
      pm_q  <= 1'b0;
      day_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      m0_q  <= m0_d;
      m1_q  <= m1_d;
      h0_q  <= h0_d;
      h1_q  <= h1_d;
      pm_q  <= pm_d;
      day_q <= day_d;
      err_q <= err_d;
    end
  end

  assign tk.sec0     = s0_q;
  assign tk.sec1     = s1_q;
  assign tk.min0     = m0_q;
  assign tk.min1     = m1_q;
  assign tk.hrs0     = h0_q;
  assign tk.hrs1     = h1_q;
  assign tk.pm       = pm_q;
  assign tk.day_tick = day_q;
  assign tk.load_err = err_q;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Directed bench for bcd_timekeeper: one 24-hour and one 12-hour instance
// share clock and reset; expected times are hand-computed BCD constants.
module tb_bcd_timekeeper;
  logic clk_6mhz = 1'b0;
  logic rst      = 1'b0;
  int   n_run    = 0;
  int   n_fail   = 0;

  bcd_timekeeper_if a ();
  bcd_timekeeper_if b ();

  bcd_timekeeper #(.H24(1'b1), .LOAD_EN(1'b1)) dut24 (
    .clk_6mhz (clk_6mhz),
    .rst      (rst),
    .tk       (a)
  );

  bcd_timekeeper #(.H24(1'b0), .LOAD_EN(1'b1)) dut12 (
    .clk_6mhz (clk_6mhz),
    .rst      (rst),
    .tk       (b)
  );

  always #5 clk_6mhz = ~clk_6mhz;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [23:0] ta();
    return {a.hrs1, a.hrs0, a.min1, a.min0, a.sec1, a.sec0};
  endfunction

  function automatic logic [23:0] tb_t();
    return {b.hrs1, b.hrs0, b.min1, b.min0, b.sec1, b.sec0};
  endfunction

  task automatic idle();
    a.clock_en = 1'b0; a.digit = 6'd0; a.up = 1'b0; a.down = 1'b0;
    a.load = 1'b0; a.load_time = 24'd0; a.load_pm = 1'b0;
    b.clock_en = 1'b0; b.digit = 6'd0; b.up = 1'b0; b.down = 1'b0;
    b.load = 1'b0; b.load_time = 24'd0; b.load_pm = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_6mhz);
    #1;
    idle();
  endtask

  task automatic load_a(input logic [23:0] t);
    a.load = 1'b1; a.load_time = t;
    step();
  endtask

  task automatic load_b(input logic [23:0] t, input logic p);
    b.load = 1'b1; b.load_time = t; b.load_pm = p;
    step();
  endtask

  task automatic adj_a(input logic [5:0] d, input logic u, input logic dn);
    a.digit = d; a.up = u; a.down = dn;
    step();
  endtask

  task automatic adj_b(input logic [5:0] d, input logic u, input logic dn);
    b.digit = d; b.up = u; b.down = dn;
    step();
  endtask

  initial begin
    idle();
    #1 rst = 1'b1;
    #2;
    check("rst24_time", {8'd0, ta()}, 32'h000000);
    check("rst12_time", {8'd0, tb_t()}, 32'h120000);
    check("rst12_pm", {31'd0, b.pm}, 32'd0);
    check("rst_day", {30'd0, a.day_tick, b.day_tick}, 32'd0);
    check("rst_err", {30'd0, a.load_err, b.load_err}, 32'd0);
    #4 rst = 1'b0;

    // 24-hour midnight rollover
    load_a(24'h235958);
    check("load_235958", {8'd0, ta()}, 32'h235958);
    check("load_ok_err", {31'd0, a.load_err}, 32'd0);
    a.clock_en = 1'b1; step();
    check("tick_235959", {8'd0, ta()}, 32'h235959);
    check("tick_235959_day", {31'd0, a.day_tick}, 32'd0);
    a.clock_en = 1'b1; step();
    check("tick_midnight", {8'd0, ta()}, 32'h000000);
    check("midnight_day", {31'd0, a.day_tick}, 32'd1);
    step();
    check("midnight_day_once", {31'd0, a.day_tick}, 32'd0);
    check("idle_hold", {8'd0, ta()}, 32'h000000);
    load_a(24'h235959);
    adj_a(6'b100000, 1'b1, 1'b0);
    check("adj_no_carry", {8'd0, ta()}, 32'h235950);
    check("adj_no_day", {31'd0, a.day_tick}, 32'd0);

    // 24-hour hour-digit adjust and clamp
    load_a(24'h193000);
    adj_a(6'b000001, 1'b1, 1'b0);
    check("hrs1_up_clamp", {8'd0, ta()}, 32'h233000);
    load_a(24'h200000);
    adj_a(6'b000010, 1'b0, 1'b1);
    check("hrs0_down_wrap3", {8'd0, ta()}, 32'h230000);
    adj_a(6'b000001, 1'b1, 1'b0);
    check("hrs1_up_wrap", {8'd0, ta()}, 32'h030000);
    adj_a(6'b000001, 1'b0, 1'b1);
    check("hrs1_down_wrap", {8'd0, ta()}, 32'h230000);

    // adjust versus tick priority
    load_a(24'h125959);
    a.digit = 6'b100000; a.up = 1'b1; a.clock_en = 1'b1; step();
    check("adj_beats_tick", {8'd0, ta()}, 32'h125950);
    a.digit = 6'b100000; a.up = 1'b1; a.down = 1'b1; a.clock_en = 1'b1; step();
    check("updown_tick", {8'd0, ta()}, 32'h125951);
    adj_a(6'b100100, 1'b1, 1'b0);
    check("twohot_noop", {8'd0, ta()}, 32'h125951);
    adj_a(6'b000100, 1'b0, 1'b1);
    check("min1_down", {8'd0, ta()}, 32'h124951);
    adj_a(6'b010000, 1'b1, 1'b0);
    check("sec1_up_wrap", {8'd0, ta()}, 32'h124901);
    adj_a(6'b100000, 1'b0, 1'b1);
    adj_a(6'b100000, 1'b0, 1'b1);
    check("sec0_down_wrap", {8'd0, ta()}, 32'h124909);
    a.load = 1'b1; a.load_time = 24'h101010;
    a.digit = 6'b100000; a.up = 1'b1; a.clock_en = 1'b1; step();
    check("load_priority", {8'd0, ta()}, 32'h101010);

    // rejected loads
    load_a(24'h240000);
    check("bad24_err", {31'd0, a.load_err}, 32'd1);
    check("bad24_hold", {8'd0, ta()}, 32'h101010);
    step();
    check("bad24_err_once", {31'd0, a.load_err}, 32'd0);
    load_a(24'h12A000);
    check("nonbcd_min_err", {31'd0, a.load_err}, 32'd1);
    load_a(24'h09595F);
    check("nonbcd_sec_err", {31'd0, a.load_err}, 32'd1);
    check("nonbcd_hold", {8'd0, ta()}, 32'h101010);

    // hour carry, then async reset in the middle of that carry
    load_a(24'h095959);
    a.clock_en = 1'b1; step();
    check("carry_100000", {8'd0, ta()}, 32'h100000);
    load_a(24'h095959);
    a.clock_en = 1'b1;
    #3 rst = 1'b1;
    #1;
    check("async_rst24", {8'd0, ta()}, 32'h000000);
    check("async_rst12", {8'd0, tb_t()}, 32'h120000);
    #1 rst = 1'b0;
    step();
    check("resume_after_rst", {8'd0, ta()}, 32'h000001);

    // 12-hour mode
    load_b(24'h115959, 1'b1);
    check("b_load_pm", {8'd0, tb_t()} ^ {31'd0, b.pm}, 32'h115958);
    b.clock_en = 1'b1; step();
    check("b_tick_12", {8'd0, tb_t()}, 32'h120000);
    check("b_tick_12_pm", {31'd0, b.pm}, 32'd0);
    check("b_midnight_day", {31'd0, b.day_tick}, 32'd1);
    step();
    check("b_day_once", {31'd0, b.day_tick}, 32'd0);
    load_b(24'h125959, 1'b0);
    b.clock_en = 1'b1; step();
    check("b_tick_01", {8'd0, tb_t()}, 32'h010000);
    check("b_tick_01_pm", {31'd0, b.pm}, 32'd0);
    check("b_tick_01_day", {31'd0, b.day_tick}, 32'd0);
    load_b(24'h003000, 1'b0);
    check("b_bad_err", {31'd0, b.load_err}, 32'd1);
    check("b_bad_hold", {8'd0, tb_t()}, 32'h010000);
    adj_b(6'b000010, 1'b0, 1'b1);
    check("b_hr_down_wrap", {8'd0, tb_t()}, 32'h120000);
    check("b_hr_adj_no_day", {31'd0, b.day_tick}, 32'd0);
    adj_b(6'b000010, 1'b1, 1'b0);
    check("b_hr_up_wrap", {8'd0, tb_t()}, 32'h010000);
    adj_b(6'b000001, 1'b0, 1'b1);
    check("b_pm_toggle", {31'd0, b.pm}, 32'd1);
    check("b_pm_toggle_time", {8'd0, tb_t()}, 32'h010000);
    check("a_pm_zero", {31'd0, a.pm}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
